// File: rtl/reg_file_pkg.sv
// Shared MIPS register-file definitions: widths and architecturally named register indices.
package reg_file_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [ADDR_W-1:0] REG_SP   = 5'd29;
  localparam logic [ADDR_W-1:0] REG_RA   = 5'd31;
endpackage

// File: rtl/reg_file_rport.sv
// One combinational read port: r0 reads as zero; with REGFILE_BYPASS_EN defined a
// same-cycle write to the addressed register is forwarded to the output.
module reg_file_rport
  import reg_file_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = ADDR_W
) (
  input  logic [AW-1:0] i_raddr,
  input  logic [DW-1:0] i_regs [2**AW],
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata
);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    o_rdata = i_regs[i_raddr];
    if (i_raddr == '0) begin
      o_rdata = '0;
    end
`ifdef REGFILE_BYPASS_EN
    else if (i_we && (i_waddr == i_raddr)) begin
      o_rdata = i_wdata;
    end
`endif
  end

`ifndef REGFILE_BYPASS_EN
  logic unused_bypass;
  assign unused_bypass = ^{i_we, i_waddr, i_wdata};
`endif

endmodule

// File: rtl/reg_file.sv
// MIPS 32x32 register file, two combinational read ports and one write port, r0 hard-wired
// to zero. Optional write-through forwarding when REGFILE_BYPASS_EN is defined.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int DATA_W = reg_file_pkg::DATA_W,
  parameter int ADDR_W = reg_file_pkg::ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_raddr_a,
  input  logic [ADDR_W-1:0] i_raddr_b,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [31:0]       wr_cnt
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [31:0]       wr_cnt_q, wr_cnt_d;
  logic              wr_valid;

  assign wr_valid = i_we && (i_waddr != REG_ZERO);

  always_comb begin
    regs_d   = regs_q;
    wr_cnt_d = wr_cnt_q;
    if (wr_valid) begin
      regs_d[i_waddr] = i_wdata;
      wr_cnt_d        = wr_cnt_q + 32'd1;
    end
  end

  // NOTE: the array is reset because software may read any register straight out of reset
  // and must see zero; state is updated only with non-blocking assignments.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      wr_cnt_q <= '0;
    end else begin
      regs_q   <= regs_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign wr_cnt = wr_cnt_q;

  reg_file_rport #(.DW(DATA_W), .AW(ADDR_W)) u_rport_a (
    .i_raddr (i_raddr_a),
    .i_regs  (regs_q),
    .i_we    (i_we),
    .i_waddr (i_waddr),
    .i_wdata (i_wdata),
    .o_rdata (out_a)
  );

  reg_file_rport #(.DW(DATA_W), .AW(ADDR_W)) u_rport_b (
    .i_raddr (i_raddr_b),
    .i_regs  (regs_q),
    .i_we    (i_we),
    .i_waddr (i_waddr),
    .i_wdata (i_wdata),
    .o_rdata (out_b)
  );

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file; expectations follow REGFILE_BYPASS_EN.
module tb_reg_file;

  logic        i_clk;
  logic        i_rst;
  logic [4:0]  i_raddr_a;
  logic [4:0]  i_raddr_b;
  logic        i_we;
  logic [4:0]  i_waddr;
  logic [31:0] i_wdata;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [31:0] wr_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  reg_file dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_raddr_a (i_raddr_a),
    .i_raddr_b (i_raddr_b),
    .i_we      (i_we),
    .i_waddr   (i_waddr),
    .i_wdata   (i_wdata),
    .out_a     (out_a),
    .out_b     (out_b),
    .wr_cnt    (wr_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Inputs change 1ns after a rising edge, so every check lands between edges.
  task automatic wr(input logic [4:0] addr, input logic [31:0] data);
    i_we    = 1'b1;
    i_waddr = addr;
    i_wdata = data;
    @(posedge i_clk);
    #1;
    i_we = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_v;
    logic [4:0]  idx;

    i_rst     = 1'b1;
    i_raddr_a = 5'd5;
    i_raddr_b = 5'd1;
    i_we      = 1'b0;
    i_waddr   = '0;
    i_wdata   = '0;
    #1;
    check("reset_out_a", out_a, 32'h0);
    check("reset_out_b", out_b, 32'h0);
    check("reset_wr_cnt", wr_cnt, 32'h0);
    repeat (2) @(posedge i_clk);
    #3;
    i_rst = 1'b0;

    // Write and read back on both ports
    wr(5'd1, 32'hfffffff3);
    wr(5'd2, 32'd2);
    i_raddr_a = 5'd1;
    i_raddr_b = 5'd2;
    #1;
    check("rd_r1_a", out_a, 32'hfffffff3);
    check("rd_r2_b", out_b, 32'h00000002);
    check("cnt_two", wr_cnt, 32'd2);

    // r0 ignores writes and never forwards
    i_raddr_a = 5'd0;
    i_we      = 1'b1;
    i_waddr   = 5'd0;
    i_wdata   = 32'h12345678;
    #1;
    check("r0_pre_edge", out_a, 32'h0);
    @(posedge i_clk);
    #1;
    i_we = 1'b0;
    check("r0_post_edge", out_a, 32'h0);
    check("r0_cnt_same", wr_cnt, 32'd2);

    // Same-cycle read/write hazard on r7; port B reads a different index meanwhile
    wr(5'd7, 32'h1);
    i_raddr_a = 5'd7;
    i_raddr_b = 5'd1;
    i_we      = 1'b1;
    i_waddr   = 5'd7;
    i_wdata   = 32'hA5A5A5A5;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("hazard_pre_edge", out_a, 32'hA5A5A5A5);
`else
    check("hazard_pre_edge", out_a, 32'h00000001);
`endif
    check("hazard_other_idx", out_b, 32'hfffffff3);
    @(posedge i_clk);
    #1;
    i_we = 1'b0;
    check("hazard_post_edge", out_a, 32'hA5A5A5A5);
    check("hazard_cnt", wr_cnt, 32'd4);

    // Mid-run reset clears contents at once; a write held across reset is dropped
    wr(5'd5, 32'hdeadbeef);
    i_raddr_a = 5'd5;
    #1;
    check("r5_before_rst", out_a, 32'hdeadbeef);
    i_we    = 1'b1;
    i_waddr = 5'd9;
    i_wdata = 32'h99999999;
    i_rst   = 1'b1;
    #1;
    check("rst_async_out_a", out_a, 32'h0);
    check("rst_async_out_b", out_b, 32'h0);
    check("rst_async_cnt", wr_cnt, 32'h0);
    @(posedge i_clk);
    #2;
    i_rst = 1'b0;
    i_we  = 1'b0;
    i_raddr_a = 5'd9;
    #1;
    check("rst_write_dropped", out_a, 32'h0);
    check("rst_write_cnt", wr_cnt, 32'h0);

    // Full sweep r1..r31
    for (int i = 1; i < 32; i++) begin
      idx = 5'(i);
      wr(idx, 32'(i) * 32'h01010101);
    end
    check("sweep_cnt", wr_cnt, 32'd31);
    for (int i = 0; i < 32; i++) begin
      i_raddr_a = 5'(i);
      i_raddr_b = 5'(31 - i);
      #1;
      exp_v = 32'(i) * 32'h01010101;
      check($sformatf("sweep_a_r%0d", i), out_a, exp_v);
      exp_v = 32'(31 - i) * 32'h01010101;
      check($sformatf("sweep_b_r%0d", 31 - i), out_b, exp_v);
    end
    i_raddr_a = 5'd29;
    i_raddr_b = 5'd29;
    #1;
    check("same_idx_a", out_a, 32'h1d1d1d1d);
    check("same_idx_b", out_b, 32'h1d1d1d1d);

    // Counter wrap
    @(posedge i_clk);
    #1;
    force dut.wr_cnt_q = 32'hffffffff;
    #1;
    release dut.wr_cnt_q;
    #1;
    check("cnt_preload", wr_cnt, 32'hffffffff);
    wr(5'd10, 32'hcafef00d);
    check("cnt_wrap", wr_cnt, 32'h0);
    i_raddr_a = 5'd10;
    #1;
    check("wrap_write_data", out_a, 32'hcafef00d);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
